// File: rtl/arc4_phase_ctrl.sv
// arc4_phase_ctrl
// ---------------
// Top-level sequencer for the ARC4 decryption datapath. One accepted request
// runs the init, KSA and PRGA sub-blocks back to back over their rdy/en
// handshakes. The block also owns the write/address port of the single-port
// S memory and hands it to whichever phase is currently active.
//
// Optional build feature: define ARC4_PHASE_CTRL_PERF_EN to add the
// 32-bit `cycles` output, a saturating count of non-idle cycles for the
// most recent request.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   en / rdy                        start request / idle-and-ready
//   key_in / key_out                key sampled on accepted en / latched copy
//   phase                           0 idle, 1 init, 2 ksa, 3 prga
//   {init,ksa,prga}_en              one-cycle start pulses to sub-blocks
//   {init,ksa,prga}_rdy             sub-block ready inputs
//   {init,ksa,prga}_addr/wrdata/wren  per-requester S memory write port
//   s_addr / s_wrdata / s_wren      muxed S memory port
//   cycles                          (ARC4_PHASE_CTRL_PERF_EN only) run length

module arc4_phase_ctrl #(
    parameter int unsigned KEY_W  = 24,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key_in,
    output logic [KEY_W-1:0]  key_out,
    output logic [1:0]        phase,

    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,

    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              prga_wren,

    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren
`ifdef ARC4_PHASE_CTRL_PERF_EN
    ,
    output logic [31:0]       cycles
`endif
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StInitReq = 3'd1,
        StInitRun = 3'd2,
        StKsaReq  = 3'd3,
        StKsaRun  = 3'd4,
        StPrgaReq = 3'd5,
        StPrgaRun = 3'd6
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               r_run_first;  // high during the first cycle of any X_RUN state
    logic               w_run_first_d;
    logic               w_key_load;
    logic [KEY_W-1:0]   r_key;

    // ------------------------------------------------------------------
    // State, key and first-run-cycle registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_run_first <= 1'b0;
            r_key       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_run_first <= w_run_first_d;
            if (w_key_load) begin
                r_key <= key_in;
            end
        end
    end

    assign key_out = r_key;

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    // A sub-block only drops rdy the cycle after it samples en, so its rdy
    // is still high in the first RUN cycle; r_run_first masks that cycle.
    always_comb begin
        w_state_d     = r_state;
        w_run_first_d = 1'b0;
        w_key_load    = 1'b0;
        rdy           = 1'b0;
        init_en       = 1'b0;
        ksa_en        = 1'b0;
        prga_en       = 1'b0;

        unique case (r_state)
            StIdle: begin
                rdy = 1'b1;
                if (en) begin
                    w_key_load = 1'b1;
                    w_state_d  = StInitReq;
                end
            end
            StInitReq: begin
                if (init_rdy) begin
                    init_en       = 1'b1;
                    w_run_first_d = 1'b1;
                    w_state_d     = StInitRun;
                end
            end
            StInitRun: begin
                if (!r_run_first && init_rdy) begin
                    w_state_d = StKsaReq;
                end
            end
            StKsaReq: begin
                if (ksa_rdy) begin
                    ksa_en        = 1'b1;
                    w_run_first_d = 1'b1;
                    w_state_d     = StKsaRun;
                end
            end
            StKsaRun: begin
                if (!r_run_first && ksa_rdy) begin
                    w_state_d = StPrgaReq;
                end
            end
            StPrgaReq: begin
                if (prga_rdy) begin
                    prga_en       = 1'b1;
                    w_run_first_d = 1'b1;
                    w_state_d     = StPrgaRun;
                end
            end
            StPrgaRun: begin
                if (!r_run_first && prga_rdy) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase indicator and S memory port mux (grant follows state group)
    // ------------------------------------------------------------------
    always_comb begin
        phase    = 2'd0;
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;

        unique case (r_state)
            StInitReq, StInitRun: begin
                phase    = 2'd1;
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            StKsaReq, StKsaRun: begin
                phase    = 2'd2;
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            StPrgaReq, StPrgaRun: begin
                phase    = 2'd3;
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                phase = 2'd0;
            end
        endcase
    end

`ifdef ARC4_PHASE_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Run-length counter: cleared on acceptance, counts non-idle cycles,
    // saturates, and holds its final value while idle.
    // ------------------------------------------------------------------
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (r_state == StIdle) begin
            if (en) begin
                r_cycles <= '0;
            end
        end else if (r_cycles != 32'hFFFF_FFFF) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_arc4_phase_ctrl.sv
module tb_arc4_phase_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key_in;
    logic [23:0] key_out;
    logic [1:0]  phase;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  init_addr, ksa_addr, prga_addr;
    logic [7:0]  init_wrdata, ksa_wrdata, prga_wrdata;
    logic        init_wren, ksa_wren, prga_wren;
    logic [7:0]  s_addr;
    logic [7:0]  s_wrdata;
    logic        s_wren;
`ifdef ARC4_PHASE_CTRL_PERF_EN
    logic [31:0] cycles;
`endif

    arc4_phase_ctrl #(
        .KEY_W  (24),
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rdy         (rdy),
        .key_in      (key_in),
        .key_out     (key_out),
        .phase       (phase),
        .init_en     (init_en),
        .ksa_en      (ksa_en),
        .prga_en     (prga_en),
        .init_rdy    (init_rdy),
        .ksa_rdy     (ksa_rdy),
        .prga_rdy    (prga_rdy),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren)
`ifdef ARC4_PHASE_CTRL_PERF_EN
        ,
        .cycles      (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub sub-blocks: rdy drops the cycle after en and stays low 4 cycles.
    logic [2:0] stub_busy [3];
    logic       init_hold;
    logic [2:0] sub_en;
    assign sub_en = {prga_en, ksa_en, init_en};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n)             stub_busy[i] <= 3'd0;
            else if (sub_en[i])     stub_busy[i] <= 3'd4;
            else if (stub_busy[i] != 3'd0) stub_busy[i] <= stub_busy[i] - 3'd1;
        end
    end

    assign init_rdy = (stub_busy[0] == 3'd0) && !init_hold;
    assign ksa_rdy  = (stub_busy[1] == 3'd0);
    assign prga_rdy = (stub_busy[2] == 3'd0);

    // Scoreboard of enable pulses: code is {prga,ksa,init}, cyc is when seen.
    typedef struct {
        logic [2:0] code;
        int         cyc;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t obs_q[$];

    always @(negedge clk) begin
        #3;
        if (sub_en != 3'b000) obs_q.push_back('{sub_en, cyc});
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int run_start;
    int run_init_at;

    // Drive en for one cycle at a negedge and queue the expected pulses.
    task automatic start_run(input logic [23:0] k, input int delay);
        en          = 1'b1;
        key_in      = k;
        run_start   = cyc;
        run_init_at = cyc + 1 + delay;
        exp_q.push_back('{3'b001, run_init_at});
        exp_q.push_back('{3'b010, run_init_at + 6});
        exp_q.push_back('{3'b100, run_init_at + 12});
        @(negedge clk);
        en     = 1'b0;
        key_in = 24'h5A5A5A;
    endtask

    task automatic check_seq(input string tag);
        pulse_t e;
        pulse_t o;
        chk({tag, "_pulse_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            else o = '{3'b000, -1};
            chk({tag, "_pulse_code"}, {29'd0, o.code}, {29'd0, e.code});
            chk({tag, "_pulse_cyc"}, o.cyc, e.cyc);
        end
        obs_q.delete();
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int i = 0; i < 100 && phase != p; i++) @(negedge clk);
        chk("phase_reach", {30'd0, phase}, {30'd0, p});
    endtask

    task automatic finish_run(input string tag, input logic [23:0] k);
        for (int i = 0; i < 300 && !rdy; i++) @(negedge clk);
        chk({tag, "_rdy_cyc"}, cyc, run_init_at + 18);
        chk({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
        check_seq(tag);
        chk({tag, "_key_out"}, {8'd0, key_out}, {8'd0, k});
        chk({tag, "_phase_idle"}, {30'd0, phase}, 32'd0);
`ifdef ARC4_PHASE_CTRL_PERF_EN
        chk({tag, "_cycles"}, cycles, run_init_at + 17 - run_start);
`endif
    endtask

    task automatic set_wr(input logic [7:0] ia, input logic [7:0] id, input logic iw,
                          input logic [7:0] ka, input logic [7:0] kd, input logic kw,
                          input logic [7:0] pa, input logic [7:0] pd, input logic pw);
        init_addr = ia; init_wrdata = id; init_wren = iw;
        ksa_addr  = ka; ksa_wrdata  = kd; ksa_wren  = kw;
        prga_addr = pa; prga_wrdata = pd; prga_wren = pw;
    endtask

    initial begin
        // Reset held with en high and every requester writing.
        rst_n     = 1'b0;
        en        = 1'b1;
        key_in    = 24'hABCDEF;
        init_hold = 1'b0;
        set_wr(8'h11, 8'h22, 1'b1, 8'h33, 8'h44, 1'b1, 8'h55, 8'h66, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        chk("rst_en_pulses", {29'd0, sub_en}, 32'd0);
        chk("rst_s_wren", {31'd0, s_wren}, 32'd0);
        chk("rst_s_addr", {24'd0, s_addr}, 32'd0);
        chk("rst_s_wrdata", {24'd0, s_wrdata}, 32'd0);
        chk("rst_phase", {30'd0, phase}, 32'd0);
        chk("rst_key_out", {8'd0, key_out}, 32'd0);
        en = 1'b0;
        set_wr(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        obs_q.delete();
        rst_n = 1'b1;
        @(negedge clk);

        // Full run with minimum latency.
        start_run(24'h00033C, 0);
        finish_run("full", 24'h00033C);

        // Mux isolation across all phases, then in idle.
        @(negedge clk);
        start_run(24'h000111, 0);
        wait_phase(2'd1);
        set_wr(8'h34, 8'h56, 1'b1, 8'h99, 8'h98, 1'b1, 8'hEE, 8'hED, 1'b1);
        #1;
        chk("mux_init_addr", {24'd0, s_addr}, 32'h34);
        chk("mux_init_data", {24'd0, s_wrdata}, 32'h56);
        wait_phase(2'd2);
        set_wr(8'hFF, 8'h77, 1'b1, 8'h12, 8'hA5, 1'b1, 8'hEE, 8'hED, 1'b1);
        #1;
        chk("mux_ksa_addr", {24'd0, s_addr}, 32'h12);
        chk("mux_ksa_data", {24'd0, s_wrdata}, 32'hA5);
        chk("mux_ksa_wren", {31'd0, s_wren}, 32'd1);
        ksa_wren = 1'b0;
        #1;
        chk("mux_ksa_wren_off", {31'd0, s_wren}, 32'd0);
        wait_phase(2'd3);
        prga_wren = 1'b0;
        #1;
        chk("mux_prga_addr", {24'd0, s_addr}, 32'hEE);
        chk("mux_prga_data", {24'd0, s_wrdata}, 32'hED);
        chk("mux_prga_wren", {31'd0, s_wren}, 32'd0);
        finish_run("mux", 24'h000111);
        set_wr(8'h12, 8'h34, 1'b1, 8'h56, 8'h78, 1'b1, 8'h9A, 8'hBC, 1'b1);
        #1;
        chk("idle_s_wren", {31'd0, s_wren}, 32'd0);
        chk("idle_s_addr", {24'd0, s_addr}, 32'd0);
        chk("idle_s_wrdata", {24'd0, s_wrdata}, 32'd0);
        set_wr(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

        // init_rdy held low for 10 cycles after INIT_REQ entry.
        @(negedge clk);
        init_hold = 1'b1;
        start_run(24'h0A0B0C, 10);
        repeat (10) @(negedge clk);
        chk("delay_no_init_yet", obs_q.size(), 32'd0);
        init_hold = 1'b0;
        finish_run("delay", 24'h0A0B0C);

        // Busy request mid-KSA must be ignored.
        @(negedge clk);
        start_run(24'h00033C, 0);
        wait_phase(2'd2);
        en     = 1'b1;
        key_in = 24'hFFFFFF;
        @(negedge clk);
        en     = 1'b0;
        chk("busy_key_hold", {8'd0, key_out}, 32'h00033C);
        finish_run("busy", 24'h00033C);

        // Asynchronous reset in the middle of PRGA.
        @(negedge clk);
        start_run(24'h123456, 0);
        wait_phase(2'd3);
        @(negedge clk);
        check_seq("abort");
        prga_wren = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s_wren", {31'd0, s_wren}, 32'd0);
        chk("arst_rdy", {31'd0, rdy}, 32'd1);
        chk("arst_phase", {30'd0, phase}, 32'd0);
        chk("arst_key_out", {8'd0, key_out}, 32'd0);
        prga_wren = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_no_pulses", obs_q.size(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(24'h654321, 0);
        finish_run("restart", 24'h654321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arc4_phase_ctrl.md
Name: arc4_phase_ctrl

Overview:
Top-level sequencer for the ARC4 decryption datapath. On one accepted request it runs the init, KSA and PRGA sub-blocks in order over their rdy/en handshakes. It owns the single-port S memory and muxes its address/write port to whichever phase is active. It sits between the task top level (switches/key) and the three sub-blocks.

Parameters:
KEY_W, 24, width of ARC4 key latched on request
ADDR_W, 8, S memory address width
DATA_W, 8, S memory data width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  start request, accepted only when rdy=1
rdy  out  1  high when idle and able to accept en
key_in  in  KEY_W  key sampled on accepted en
key_out  out  KEY_W  latched key to ksa/prga
phase  out  2  0 idle, 1 init, 2 ksa, 3 prga
init_en / ksa_en / prga_en  out  1 each  one-cycle start pulses to sub-blocks
init_rdy / ksa_rdy / prga_rdy  in  1 each  sub-block ready
init_addr / ksa_addr / prga_addr  in  ADDR_W each  requester S addresses
init_wrdata / ksa_wrdata / prga_wrdata  in  DATA_W each  requester write data
init_wren / ksa_wren / prga_wren  in  1 each  requester write enables
s_addr  out  ADDR_W  S memory address
s_wrdata  out  DATA_W  S memory write data
s_wren  out  1  S memory write enable

Behaviour:
- Reset (async, rst_n=0): state IDLE; rdy=1; all *_en=0; s_wren=0; s_addr=0; s_wrdata=0; key_out=0; phase=0. Reset mid-run aborts immediately, no further enables issued.
- States: IDLE, INIT_REQ, INIT_RUN, KSA_REQ, KSA_RUN, PRGA_REQ, PRGA_RUN.
- IDLE: rdy=1. en=1 -> latch key_in into key_out, go INIT_REQ, rdy=0 next cycle. en while rdy=0 ignored.
- X_REQ: wait for X_rdy=1; in that cycle assert X_en for exactly one cycle (combinational from state and X_rdy) and go X_RUN.
- X_RUN: X_rdy ignored in the first X_RUN cycle (sub-block drops rdy the cycle after sampling en). From the second cycle, X_rdy=1 -> next phase REQ (INIT->KSA->PRGA), or PRGA -> IDLE.
- Min latency: en accepted at cycle 0; init_en at cycle 1 if init_rdy already high. rdy returns the cycle after the PRGA_RUN completion condition.
- Memory mux: grant by state. INIT_* selects init_*, KSA_* selects ksa_*, PRGA_* selects prga_*. IDLE drives s_addr=0, s_wrdata=0, s_wren=0. Non-granted requester wren never reaches memory. Mux is combinational, zero latency. s_rddata fans out directly to all sub-blocks and is outside this block.
- phase follows state group; key_out stable from acceptance until next accepted en.
- Sub-block rdy never asserting: controller waits indefinitely (no timeout in base build).

Optional Feature:
Macro ARC4_PHASE_CTRL_PERF_EN.
- Defined: adds output cycles[31:0]. A counter clears on accepted en and increments every non-IDLE cycle, saturating at 0xFFFFFFFF. Value holds in IDLE until the next en. Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: rst_n low for 2 cycles with en=1 -> rdy=1, all *_en=0, s_wren=0, phase=0, key_out=0.
- Full run with stub sub-blocks (each rdy drops 1 cycle after en, busy 4 cycles) and key_in=24'h00033C -> init_en, ksa_en, prga_en each pulse exactly once in order, key_out=24'h00033C, rdy back to 1. With PERF_EN, cycles=18.
- Mux isolation: during KSA phase, force init_wren=1 and init_addr=8'hFF, with ksa_addr=8'h12, ksa_wrdata=8'hA5, ksa_wren=1 -> s_addr=8'h12, s_wrdata=8'hA5, s_wren=1. In IDLE, all three wren=1 -> s_wren=0.
- Delayed ready: init_rdy held 0 for 10 cycles after INIT_REQ entry -> init_en stays 0 and fires once, on the cycle init_rdy rises.
- Busy request: pulse en with key_in=24'hFFFFFF mid-KSA -> ignored, key_out unchanged, single sequence completes.
- Async reset mid-PRGA: drop rst_n between clock edges -> s_wren=0, rdy=1, phase=0 immediately. New en afterwards restarts from init.
